// File: rtl/vga_sync_timing.sv
// 640x480@60 VGA timing: pixel-enable divider, h/v counters, registered sync and blanked colour.
// Sync, video_on and colour are all loaded on the same pix_en, so they share a one-pixel delay.
module vga_sync_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Rin,
  input  logic [3:0] Gin,
  input  logic [3:0] Bin,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       pix_en,
  output logic       frame_start
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          fs_q, fs_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          vo_q, vo_d;
  logic [11:0]   rgb_q, rgb_d;

  logic vis, hs_a, vs_a;

  always_comb begin
    vis  = (x_q < H_VIS_C) && (y_q < V_VIS_C);
    hs_a = (x_q >= HS_BEG) && (x_q < HS_END);
    vs_a = (y_q >= VS_BEG) && (y_q < VS_END);
  end

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    // registered so it is high during the clock in which div == CLK_DIV-1
    pix_en_d = (div_q == DIV_PRE);
    x_d      = x_q;
    y_d      = y_q;
    fs_d     = 1'b0;
    hs_d     = hs_q;
    vs_d     = vs_q;
    vo_d     = vo_q;
    rgb_d    = rgb_q;
    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      fs_d  = (x_q == H_LAST) && (y_q == V_LAST);
      hs_d  = hs_a ? SYNC_POL : ~SYNC_POL;
      vs_d  = vs_a ? SYNC_POL : ~SYNC_POL;
      vo_d  = vis;
      rgb_d = vis ? {Rin, Gin, Bin} : 12'h000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      vo_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fs_q     <= fs_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      vo_q     <= vo_d;
      rgb_q    <= rgb_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vo_q;
  assign R           = rgb_q[11:8];
  assign G           = rgb_q[7:4];
  assign B           = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sync_timing.sv
// Directed bench for vga_sync_timing: a shrunken-geometry instance for whole frames and a
// default-geometry instance for real 640x480 line timing, both checked against an index model.
module tb_vga_sync_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] s_rin, s_gin, s_bin, f_rin, f_gin, f_bin;
  logic       s_hsync, s_vsync, s_video_on, s_pix_en, s_frame_start;
  logic       f_hsync, f_vsync, f_video_on, f_pix_en, f_frame_start;
  logic [3:0] s_r, s_g, s_b, f_r, f_g, f_b;
  logic [9:0] s_pix_x, s_pix_y, f_pix_x, f_pix_y;

  vga_sync_timing #(
    .CLK_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .Rin(s_rin), .Gin(s_gin), .Bin(s_bin),
    .hsync(s_hsync), .vsync(s_vsync), .R(s_r), .G(s_g), .B(s_b),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .video_on(s_video_on),
    .pix_en(s_pix_en), .frame_start(s_frame_start)
  );

  vga_sync_timing dut_f (
    .clk(clk), .rst(rst), .Rin(f_rin), .Gin(f_gin), .Bin(f_bin),
    .hsync(f_hsync), .vsync(f_vsync), .R(f_r), .G(f_g), .B(f_b),
    .pix_x(f_pix_x), .pix_y(f_pix_y), .video_on(f_video_on),
    .pix_en(f_pix_en), .frame_start(f_frame_start)
  );

  int cd [2] = '{4, 4};
  int hv [2] = '{16, 640};
  int hf [2] = '{2, 16};
  int hs [2] = '{4, 96};
  int hb [2] = '{3, 48};
  int vv [2] = '{8, 480};
  int vf [2] = '{2, 10};
  int vs [2] = '{2, 2};
  int vb [2] = '{3, 33};

  int n = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit const_phase = 1'b1;
  logic [11:0] exp_rgb [2];
  logic [11:0] drv_good [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [11:0] col(input int m, input int x, input int y);
    logic [3:0] xl, yl;
    xl = x[3:0];
    yl = y[3:0];
    return (m == 0) ? 12'hF0F : {xl, yl, ~xl};
  endfunction

  function automatic int htot(input int d);
    return hv[d] + hf[d] + hs[d] + hb[d];
  endfunction

  function automatic int vtot(input int d);
    return vv[d] + vf[d] + vs[d] + vb[d];
  endfunction

  function automatic bit vis_of(input int d, input int q);
    int qx, qy;
    qx = q % htot(d);
    qy = (q / htot(d)) % vtot(d);
    return (qx < hv[d]) && (qy < vv[d]);
  endfunction

  task automatic check_dut(input int d);
    int p, x, y, q, qx, qy;
    logic vis, hsa, vsa, e_pe, e_fs;
    logic pe, fs, hsy, vsy, vo;
    logic [9:0] ox, oy;
    logic [11:0] rgb;
    string nm;
    p    = n / cd[d];
    x    = p % htot(d);
    y    = (p / htot(d)) % vtot(d);
    e_pe = (n % cd[d]) == cd[d] - 1;
    e_fs = (n > 0) && (n % cd[d] == 0) && (p % (htot(d) * vtot(d)) == 0);
    vis = 1'b0; hsa = 1'b0; vsa = 1'b0;
    if (p > 0) begin
      q   = p - 1;
      qx  = q % htot(d);
      qy  = (q / htot(d)) % vtot(d);
      vis = vis_of(d, q);
      hsa = (qx >= hv[d] + hf[d]) && (qx < hv[d] + hf[d] + hs[d]);
      vsa = (qy >= vv[d] + vf[d]) && (qy < vv[d] + vf[d] + vs[d]);
    end
    if (d == 0) begin
      nm = "s"; pe = s_pix_en; fs = s_frame_start; hsy = s_hsync; vsy = s_vsync;
      vo = s_video_on; ox = s_pix_x; oy = s_pix_y; rgb = {s_r, s_g, s_b};
    end else begin
      nm = "f"; pe = f_pix_en; fs = f_frame_start; hsy = f_hsync; vsy = f_vsync;
      vo = f_video_on; ox = f_pix_x; oy = f_pix_y; rgb = {f_r, f_g, f_b};
    end
    chk({nm, "_pix_en"}, 32'(pe), 32'(e_pe));
    chk({nm, "_pix_x"}, 32'(ox), 32'(x));
    chk({nm, "_pix_y"}, 32'(oy), 32'(y));
    chk({nm, "_frame_start"}, 32'(fs), 32'(e_fs));
    chk({nm, "_video_on"}, 32'(vo), 32'(vis));
    chk({nm, "_hsync"}, 32'(hsy), 32'(!hsa));
    chk({nm, "_vsync"}, 32'(vsy), 32'(!vsa));
    chk({nm, "_rgb"}, 32'(rgb), 32'(exp_rgb[d]));
  endtask

  // Correct colour is present only across the sampling edge; junk otherwise.
  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      int p, x, y, m;
      logic [11:0] g, v;
      p = n / cd[d];
      x = p % htot(d);
      y = (p / htot(d)) % vtot(d);
      m = (d == 0 && const_phase && n < 1500) ? 0 : 1;
      g = col(m, x, y);
      if (n % cd[d] == cd[d] - 1) begin
        drv_good[d] = g;
        v = g;
      end else begin
        v = ~g;
      end
      if (d == 0) {s_rin, s_gin, s_bin} = v;
      else        {f_rin, f_gin, f_bin} = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) n++;
    for (int d = 0; d < 2; d++) begin
      if (n > 0 && n % cd[d] == 0)
        exp_rgb[d] = vis_of(d, n / cd[d] - 1) ? drv_good[d] : 12'h000;
    end
    check_dut(0);
    check_dut(1);
    drive();
  endtask

  int hs_first, hs_low, vs_low, fs_s, fs_f, fs_at;
  bit found;

  initial begin
    {s_rin, s_gin, s_bin} = 12'h000;
    {f_rin, f_gin, f_bin} = 12'h000;
    exp_rgb  = '{12'h000, 12'h000};
    drv_good = '{12'h000, 12'h000};
    repeat (3) @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
    rst = 1'b0;
    drive();

    // two shrunken frames (constant then per-pixel colour) and just over one full-size line
    hs_first = -1; hs_low = 0; vs_low = 0; fs_s = 0; fs_f = 0;
    for (int i = 0; i < 3400; i++) begin
      tick();
      if (!f_hsync) begin
        if (hs_first < 0) hs_first = n;
        hs_low++;
      end
      if (!s_vsync) vs_low++;
      if (s_frame_start) fs_s++;
      if (f_frame_start) fs_f++;
    end
    chk("f_hsync_first_low", 32'(hs_first), 32'd2628);
    chk("f_hsync_low_clks", 32'(hs_low), 32'd384);
    chk("s_vsync_low_clks", 32'(vs_low), 32'd400);
    chk("s_frame_start_cnt", 32'(fs_s), 32'd2);
    chk("f_frame_start_cnt", 32'(fs_f), 32'd0);

    // reset asynchronously in the middle of a pixel on line 5 of the small frame
    const_phase = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1600 && !found; i++) begin
      tick();
      if (((n / 4) % 375) == 128 && (n % 4) == 1) found = 1'b1;
    end
    chk("midframe_point_found", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    n = 0;
    exp_rgb = '{12'h000, 12'h000};
    check_dut(0);
    check_dut(1);
    tick();
    tick();
    rst = 1'b0;
    drive();

    fs_at = -1; fs_s = 0;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (s_frame_start) begin
        if (fs_at < 0) fs_at = n;
        fs_s++;
      end
    end
    chk("s_frame_start_after_rst", 32'(fs_at), 32'd1500);
    chk("s_frame_start_cnt_rst", 32'(fs_s), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
